ro_trng_ctrl: RTL

RO_TRNG_CTRL -- requirements
Module: ro_trng_ctrl

---
 rtl/ro_trng_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ro_trng_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ro_trng_ctrl
// Brief    : Ring-oscillator TRNG controller. Enables the RO, waits for it to
//            settle, XOR-folds ACCUM raw samples into one output word and
//            offers it on a valid/ready handshake.
//            Optional repetition-count health test, enabled by defining the
//            macro RO_TRNG_HEALTH_EN. When it trips, the controller parks in
//            a sticky FAULT state until fault_clr_i is asserted.
// Revision : 1.0 - initial release
// ============================================================================
module ro_trng_ctrl #(
    parameter int WIDTH         = 8,
    parameter int WARMUP_CYCLES = 16,
    parameter int ACCUM         = 4,
    parameter int REP_LIMIT     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic [WIDTH-1:0] ro_data_i,
    output logic             ro_en_o,
    output logic [WIDTH-1:0] rnd_data_o,
    output logic             rnd_valid_o,
    input  logic             rnd_ready_i,
    output logic             fault_o,
    input  logic             fault_clr_i,
    output logic             busy_o
);

    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int ACC_W  = $clog2(ACCUM + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WARMUP  = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    // Terminal counts: the transition happens on the edge that sees these.
    localparam logic [WARM_W-1:0] C_WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [ACC_W-1:0]  C_ACC_LAST  = ACC_W'(ACCUM - 1);

    logic [2:0]        state_q, state_d;
    logic [WARM_W-1:0] wcnt_q, wcnt_d;
    logic [ACC_W-1:0]  acnt_q, acnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              ro_en_q, ro_en_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;
    logic              rep_fault;

`ifdef RO_TRNG_HEALTH_EN
    localparam int               REP_W       = $clog2(REP_LIMIT + 1);
    localparam logic [REP_W-1:0] C_REP_LIMIT = REP_W'(REP_LIMIT);

    logic [REP_W-1:0] rep_q, rep_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    // Repetition count: run length of identical samples within one COLLECT
    // visit. Held at zero outside COLLECT so every entry starts a new run.
    always_comb begin
        rep_d     = '0;
        prev_d    = prev_q;
        rep_fault = 1'b0;
        if (state_q == S_COLLECT) begin
            prev_d = ro_data_i;
            if ((rep_q != '0) && (ro_data_i == prev_q)) begin
                rep_d = (rep_q == C_REP_LIMIT) ? rep_q : rep_q + REP_W'(1);
            end else begin
                rep_d = REP_W'(1);
            end
            rep_fault = (rep_d == C_REP_LIMIT);
        end
    end

    // Health-test registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q  <= '0;
            prev_q <= '0;
        end else begin
            rep_q  <= rep_d;
            prev_q <= prev_d;
        end
    end
`else
    logic w_unused;

    // No health test: the fault path never fires and fault_clr_i has no use.
    assign rep_fault = 1'b0;
    assign w_unused  = fault_clr_i ^ (REP_LIMIT != 0);
`endif

    // State register and registered state-decoded outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ro_en_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ro_en_q <= ro_en_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    // Next state plus counter/accumulator/output-word updates.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        acnt_d  = acnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (req_i) begin
                    state_d = S_WARMUP;
                    wcnt_d  = '0;
                end
            end
            S_WARMUP: begin
                if (!req_i) begin
                    state_d = S_IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q == C_WARM_LAST) begin
                    state_d = S_COLLECT;
                    wcnt_d  = '0;
                    acnt_d  = '0;
                    acc_d   = '0;
                end else begin
                    wcnt_d = wcnt_q + WARM_W'(1);
                end
            end
            S_COLLECT: begin
                // A failed health test outranks both a drop of req and a
                // word that would otherwise complete on this edge.
                if (rep_fault) begin
                    state_d = S_FAULT;
                    valid_d = 1'b0;
                    acnt_d  = '0;
                    acc_d   = '0;
                end else if (!req_i) begin
                    state_d = S_IDLE;
                    acnt_d  = '0;
                    acc_d   = '0;
                end else if (acnt_q == C_ACC_LAST) begin
                    state_d = S_HOLD;
                    data_d  = acc_q ^ ro_data_i;
                    valid_d = 1'b1;
                    acnt_d  = '0;
                    acc_d   = '0;
                end else begin
                    acc_d  = acc_q ^ ro_data_i;
                    acnt_d = acnt_q + ACC_W'(1);
                end
            end
            S_HOLD: begin
                // req alone never retracts a word already on offer.
                if (rnd_ready_i) begin
                    valid_d = 1'b0;
                    acnt_d  = '0;
                    acc_d   = '0;
                    state_d = req_i ? S_COLLECT : S_IDLE;
                end
            end
            S_FAULT: begin
                valid_d = 1'b0;
`ifdef RO_TRNG_HEALTH_EN
                if (fault_clr_i) begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State-decoded outputs, computed from the next state so they register
    // in step with it.
    always_comb begin
        ro_en_d = (state_d == S_WARMUP) || (state_d == S_COLLECT) ||
                  (state_d == S_HOLD);
        busy_d  = (state_d != S_IDLE);
        fault_d = (state_d == S_FAULT);
    end

    // Datapath registers: counters, accumulator and the output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q  <= '0;
            acnt_q  <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            acnt_q  <= acnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign ro_en_o     = ro_en_q;
    assign rnd_data_o  = data_q;
    assign rnd_valid_o = valid_q;
    assign fault_o     = fault_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire
